// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment scanner (common anode, active-low pins) with dead-time
// blanking and frame-synchronous double-buffered loading. Define SEVSEG_LZB_EN for leading-zero blanking.

module seven_seg_digit (
    input  logic [3:0] nibble,
    input  logic       sel,
    input  logic       en,
    input  logic       lz,
    output logic [6:0] seg_lane,
    output logic       act
);
    logic [6:0] pat;

    always_comb begin
        unique case (nibble)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
    end

    // Inactive lanes present all-ones so the top can AND-reduce the lanes.
    assign act      = sel && en && !lz;
    assign seg_lane = act ? pat : 7'h7F;
endmodule

module seven_seg_scan_n #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 30000,
    parameter int BLANK_CYCLES = 600,
    parameter int CNT_W        = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);
    localparam int SLOT  = BLANK_CYCLES + ON_CYCLES;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]      shadow, pending, digits_p;
    logic                            pend_v;
    logic                            first_done;

    logic                            slot_end, last_idx, boundary, in_blank;
    logic [NUM_DIGITS-1:0]           sel, lane_en, lz, act;
    logic [NUM_DIGITS-1:0][6:0]      seg_lane;
    logic [6:0]                      seg_nxt;

    assign digits_p = digits;
    assign slot_end = (cnt == CNT_W'(SLOT - 1));
    assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary = slot_end && last_idx;

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEVSEG_LZB_EN
    // Digit i is a leading zero when it and every more significant shadow digit is zero.
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (shadow[i] == 4'd0);
            lz[i] = run && (i != 0);
        end
    end
`else
    assign lz = '0;
`endif

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
            assign sel[i]     = (idx == IDX_W'(i));
            assign lane_en[i] = digit_en[i] && !in_blank;

            seven_seg_digit u_dig (
                .nibble   (shadow[i]),
                .sel      (sel[i]),
                .en       (lane_en[i]),
                .lz       (lz[i]),
                .seg_lane (seg_lane[i]),
                .act      (act[i])
            );
        end
    endgenerate

    always_comb begin
        seg_nxt = 7'h7F;
        for (int i = 0; i < NUM_DIGITS; i++)
            seg_nxt = seg_nxt & seg_lane[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            idx         <= '0;
            seg         <= 7'h7F;
            an_n        <= '1;
            frame_start <= 1'b0;
            shadow      <= '0;
            pending     <= '0;
            pend_v      <= 1'b0;
            first_done  <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= last_idx ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            seg         <= seg_nxt;
            an_n        <= ~act;
            frame_start <= first_done && (idx == '0) && (cnt == '0);

            if (load)
                pending <= digits_p;

            // Shadow only moves on the frame boundary, so a frame never shows mixed values.
            if (boundary) begin
                first_done <= 1'b1;
                pend_v     <= 1'b0;
                if (load)
                    shadow <= digits_p;
                else if (pend_v)
                    shadow <= pending;
            end else if (load) begin
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Scoreboard bench for seven_seg_scan_n with NUM_DIGITS=4, ON_CYCLES=8, BLANK_CYCLES=2.

module tb_seven_seg_scan_n;
    localparam int N     = 4;
    localparam int ON    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = BL + ON;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [15:0]  digits = 16'h0000;
    logic         load = 1'b0;
    logic [3:0]   digit_en = 4'hF;
    logic [6:0]   seg;
    logic [3:0]   an_n;
    logic         frame_start;

    seven_seg_scan_n #(.NUM_DIGITS(N), .ON_CYCLES(ON), .BLANK_CYCLES(BL), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits      (digits),
        .load        (load),
        .digit_en    (digit_en),
        .seg         (seg),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   kcnt;

    logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got an_n/seg/fs=%h/%h/%b want %h/%h/%b", name,
                      act[11:8], act[7:1], act[0], expv[11:8], expv[7:1], expv[0]);
    endtask

    // Edges since reset release; after edge k the outputs reflect state k-1.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) kcnt <= 0;
        else          kcnt <= kcnt + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].k <= kcnt) begin
            mon_e = q.pop_front();
            if (mon_e.k != kcnt)
                chk($sformatf("stale_k%0d", mon_e.k), 12'h000, 12'hFFF);
            else
                chk($sformatf("out_k%0d", mon_e.k), {an_n, seg, frame_start},
                    {mon_e.an, mon_e.seg, mon_e.fs});
        end
    end

    int          p;
    logic [15:0] cur, pend;
    bit          pv;

    function automatic exp_t expect_at(int pp);
        exp_t e;
        int   c, ix;
        logic [3:0] nib;
        bit   lzb, blank;
        c   = pp % SLOT;
        ix  = (pp / SLOT) % N;
        nib = cur[4*ix +: 4];
        lzb = 1'b0;
`ifdef SEVSEG_LZB_EN
        lzb = (ix > 0);
        for (int j = ix; j < N; j++)
            if (cur[4*j +: 4] != 4'd0) lzb = 1'b0;
`endif
        blank = (c < BL) || !digit_en[ix] || lzb;
        e.k   = pp + 1;
        e.an  = blank ? 4'hF : ~(4'b0001 << ix);
        e.seg = blank ? 7'h7F : dec_tab[nib];
        e.fs  = (c == 0) && (ix == 0) && (pp >= FRAME);
        return e;
    endfunction

    task automatic step();
        q.push_back(expect_at(p));
        if (load) begin
            pend = digits;
            pv   = 1'b1;
        end
        if (p % FRAME == FRAME - 1 && pv) begin
            cur = pend;
            pv  = 1'b0;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        p++;
    endtask

    task automatic run_to(input int stop_p);
        while (p < stop_p) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        digits = v;
        load   = 1'b1;
        step();
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.k = 0; e.an = 4'hF; e.seg = 7'h7F; e.fs = 1'b0;
        q.push_back(e);
    endtask

    initial begin
        cur = 16'h0; pend = 16'h0; pv = 1'b0; p = 0;
        #1;
        push_reset_exp();
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        run_to(85);
        do_load(16'h1F8A);          // mid-frame load shows from frame 3
        run_to(199);
        do_load(16'h1234);          // load on the boundary cycle
        run_to(205);
        do_load(16'hABCD);
        run_to(230);
        do_load(16'h5678);          // second load in the frame wins
        run_to(280);
        digit_en = 4'b1011;
        run_to(320);
        digit_en = 4'hF;
        run_to(335);

        // Asynchronous reset in the ON phase of digit 1.
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk("async_reset", {an_n, seg, frame_start}, {4'hF, 7'h7F, 1'b0});
        push_reset_exp();
        cur = 16'h0; pend = 16'h0; pv = 1'b0; p = 0;
        digits = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        run_to(90);
        do_load(16'h0050);
        run_to(170);
        do_load(16'h0000);
        run_to(245);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 12'(q.size()), 12'h000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_n.md
Name: seven_seg_scan_n

Overview:
- Parametrised N-digit time-multiplexed seven-segment driver for common-anode displays with PNP anode switches.
- Generalises the two-digit 100 Hz scanner in three ways:
  - N digits instead of two.
  - A programmable dead-time (ghost blanking) between digit slots.
  - Frame-synchronous double-buffered loading of the displayed value.
- Sits between the top-level datapath (digit nibbles) and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- ON_CYCLES, 30000, clk cycles each anode is driven per slot; must be >= 1.
- BLANK_CYCLES, 600, clk cycles of all-off dead time at the start of each slot; 0 is legal and means no blank phase.
- CNT_W, 24, width of the slot counter; must satisfy 2^CNT_W >= ON_CYCLES+BLANK_CYCLES.

Ports:
- clk  input  1  system clock (12 MHz on board).
- reset_n  input  1  asynchronous active-low reset.
- digits  input  4*NUM_DIGITS  hex nibbles; digit i is bits [4i+3:4i]; digit NUM_DIGITS-1 is most significant.
- load  input  1  one-cycle strobe; captures digits into the pending buffer.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off for its slot.
- seg  output  7  active-low segments, bit0=a ... bit6=g.
- an_n  output  NUM_DIGITS  active-low one-hot anode drive (PNP base).
- frame_start  output  1  one-cycle pulse at the start of digit 0's slot.

Behaviour:
- Reset values (reset_n=0, applied asynchronously and immediately, including mid-slot):
  - cnt=0, idx=0.
  - an_n all 1, seg=7'h7F, frame_start=0.
  - shadow=0, pending=0, pend_v=0.
- Slot timing:
  - SLOT = BLANK_CYCLES + ON_CYCLES.
  - cnt counts 0..SLOT-1. At SLOT-1, cnt returns to 0 and idx increments.
  - idx wraps from NUM_DIGITS-1 to 0.
  - Frame period is NUM_DIGITS*SLOT cycles.
- Phases within a slot:
  - BLANK phase (cnt < BLANK_CYCLES): an_n all 1, seg=7'h7F.
  - ON phase: an_n[idx]=0, all other anode bits 1, seg=decode(shadow[idx]).
  - A digit with digit_en[idx]=0 behaves as BLANK for its whole slot. It keeps its time share, so the brightness of the other digits is unchanged.
- Output registering:
  - seg, an_n and frame_start are registered and reflect the (idx, cnt) of the previous cycle, i.e. 1-cycle latency.
  - No combinational path from inputs to pins.
- Segment decode (seg, active-low, bit6..bit0 = g..a):
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - A → 0001000
  - b → 0000011
  - C → 1000110
  - d → 0100001
  - E → 0000110
  - F → 0001110
- Double buffering:
  - load=1 sets pending<=digits and pend_v<=1.
  - A frame boundary is the cycle where idx=NUM_DIGITS-1 and cnt=SLOT-1. On a boundary with pend_v=1: shadow<=pending, pend_v<=0.
  - load coincident with a boundary: digits go straight to shadow and pend_v stays 0.
  - Multiple loads within one frame: the last one wins.
  - The displayed value never changes mid-frame.
- frame_start:
  - Asserted for exactly one cycle, aligned with the first registered output cycle of idx=0, cnt=0.
  - Not asserted on the first frame after reset.
- digit_en: sampled every cycle, no buffering.

Optional Feature:
- Macro: SEVSEG_LZB_EN (leading-zero blanking).
- Defined:
  - In the ON phase, digit i is blanked (seg=7'h7F, anode off) when shadow digits NUM_DIGITS-1..i are all 0 and i>0.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - Blanking is evaluated on shadow, so it is frame-stable.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan (NUM_DIGITS=4, ON_CYCLES=8, BLANK_CYCLES=2, SLOT=10):
- Release reset with digits=16'h0000 → an_n=4'b1111 and seg=7'h7F for 2 cycles, then an_n=4'b1110 and seg=1000000 for 8 cycles. Next slot an_n=4'b1101. frame_start pulses every 40 cycles.
- Pulse load with digits=16'h1F8A at cycle 5 of frame → displayed value unchanged until the boundary. Next frame shows A, 8, F, 1 on anodes 0..3: seg 0001000, 0000000, 0001110, 1111001.
- Pulse load on the exact boundary cycle → new value appears in the immediately following frame with no extra frame delay. Two loads in one frame → only the second is displayed.
- digit_en=4'b1011 → an_n[2] never 0. Slots 0, 1 and 3 keep 8-cycle ON phases, and the frame stays at 40 cycles.
- Assert reset_n=0 mid-ON phase → an_n=4'b1111 and seg=7'h7F without waiting for a clk edge. After release, the scan restarts at digit 0 with shadow=0.
- SEVSEG_LZB_EN defined, value 16'h0050 → digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → only digit 0 shows 0.
